// File: rtl/demux_1x7_reg_if.sv
// Producer/consumer bundle for the 1-to-7 registered demux.
interface demux_1x7_reg_if;
  localparam int unsigned DW  = 4;
  localparam int unsigned SW  = 3;
  localparam int unsigned NCH = 7;
  localparam int unsigned CW  = 4;

  logic [DW-1:0]  D;
  logic [SW-1:0]  S;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  Y0;
  logic [DW-1:0]  Y1;
  logic [DW-1:0]  Y2;
  logic [DW-1:0]  Y3;
  logic [DW-1:0]  Y4;
  logic [DW-1:0]  Y5;
  logic [DW-1:0]  Y6;
  logic [NCH-1:0] V;
  logic [NCH-1:0] ack;
  logic           err;
  logic [CW-1:0]  drop_cnt;

  // Design side
  modport slave (
    input  D, S, in_valid, ack,
    output in_ready, Y0, Y1, Y2, Y3, Y4, Y5, Y6, V, err, drop_cnt
  );

  // Producer/consumer side
  modport master (
    output D, S, in_valid, ack,
    input  in_ready, Y0, Y1, Y2, Y3, Y4, Y5, Y6, V, err, drop_cnt
  );
endinterface

// File: rtl/demux_1x7_reg.sv
// Routes a 4-bit word to one of seven holding registers, each with its own
// valid/ack consume handshake; select 111 is dropped and counted.
module demux_1x7_reg (
  input logic            clk,
  input logic            rst_n,
  demux_1x7_reg_if.slave bus
);
  localparam int unsigned DW  = 4;
  localparam int unsigned SW  = 3;
  localparam int unsigned NCH = 7;
  localparam int unsigned CW  = 4;
  localparam logic [SW-1:0] ILLEGAL_SEL = 3'b111;
  localparam logic [CW-1:0] CNT_MAX     = 4'hF;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ch_state_e;

  ch_state_e     st_q [NCH];
  ch_state_e     st_d [NCH];
  logic [DW-1:0] y_q  [NCH];
  logic [DW-1:0] y_d  [NCH];
  logic          err_q;
  logic          err_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic [NCH-1:0] v;
  logic [NCH:0]   v_pad;
  logic [NCH:0]   ack_pad;
  logic           sel_illegal;
  logic           in_ready_c;
  logic           accept;

  // Valid flags are the channel states themselves
  always_comb begin
    v = '0;
    for (int k = 0; k < NCH; k++) begin
      v[k] = (st_q[k] == FULL);
    end
  end

  // Padding to 8 entries lets S index directly; the illegal code always accepts
  assign v_pad       = {1'b0, v};
  assign ack_pad     = {1'b0, bus.ack};
  assign sel_illegal = (bus.S == ILLEGAL_SEL);
  assign in_ready_c  = sel_illegal | ~v_pad[bus.S] | ack_pad[bus.S];
  assign accept      = bus.in_valid & in_ready_c;

  // Channel state, holding registers, error pulse and drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        st_q[k] <= EMPTY;
        y_q[k]  <= '0;
      end
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        st_q[k] <= st_d[k];
        y_q[k]  <= y_d[k];
      end
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  // Per-channel EMPTY/FULL transitions; a write wins over a same-cycle ack
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      st_d[k] = st_q[k];
      y_d[k]  = y_q[k];
    end
    err_d = 1'b0;
    cnt_d = cnt_q;

    for (int k = 0; k < NCH; k++) begin
      if (accept && !sel_illegal && (bus.S == SW'(k))) begin
        st_d[k] = FULL;
        y_d[k]  = bus.D;
      end else begin
        case (st_q[k])
          EMPTY: st_d[k] = EMPTY;
          FULL:  if (bus.ack[k]) st_d[k] = EMPTY;
        endcase
      end
    end

    if (accept && sel_illegal) begin
      err_d = 1'b1;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Output mapping
  assign bus.in_ready = in_ready_c;
  assign bus.Y0       = y_q[0];
  assign bus.Y1       = y_q[1];
  assign bus.Y2       = y_q[2];
  assign bus.Y3       = y_q[3];
  assign bus.Y4       = y_q[4];
  assign bus.Y5       = y_q[5];
  assign bus.Y6       = y_q[6];
  assign bus.V        = v;
  assign bus.err      = err_q;
  assign bus.drop_cnt = cnt_q;
endmodule

// File: doc/demux_1x7_reg.md
DEMUX_1X7_REG -- requirements
Module: demux_1x7_reg

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port D, input, 4 bits: data word to route.
REQ-004 SHALL have port S, input, 3 bits: destination select, where S[2]=S2 is the MSB and S[0]=S0 is the LSB; codes 000..110 select channels 0..6 and 111 is illegal.
REQ-005 SHALL have port in_valid, input, 1 bit: D and S are presented this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept a word this cycle (combinational).
REQ-007 SHALL have ports Y0..Y6, output, 4 bits each: per-channel holding registers.
REQ-008 SHALL have port V, output, 7 bits: V[k] = Yk holds unconsumed data.
REQ-009 SHALL have port ack, input, 7 bits: ack[k] = consumer of channel k takes Yk this cycle.
REQ-010 SHALL have port err, output, 1 bit: one-cycle pulse when an illegal select is accepted.
REQ-011 SHALL have port drop_cnt, output, 4 bits: saturating count of illegal-select words.

Function
REQ-012 SHALL use the handshake rule: a word is accepted when in_valid=1 and in_ready=1 at a rising clk edge.
REQ-013 SHALL drive in_ready = ~V[S] | ack[S] for S in 000..110, and in_ready = 1 for S=111.
REQ-014 SHALL, when a word with legal S=k is accepted, load Yk<=D and set V[k]<=1 at the same edge; the data is visible 1 cycle after acceptance.
REQ-015 SHALL leave the Yj and V[j] of all non-selected channels unchanged by a write.
REQ-016 SHALL clear V[k] at the edge when ack[k]=1 and V[k]=1, unless the same edge writes channel k.
REQ-017 SHALL give priority to the write when ack[k]=1 and a write to k are both accepted in the same cycle: V[k] stays 1 and Yk takes the new D (consumer takes the old value that cycle).
REQ-018 SHALL ignore ack[k] when V[k]=0: no state change, no error.
REQ-019 SHALL hold Yk after V[k] clears; Yk is not zeroed on consume.
REQ-020 SHALL, for an accepted word with S=111, write no channel, pulse err=1 for exactly the next cycle, and increment drop_cnt, saturating at 15.
REQ-021 SHALL keep D and S sampled only at acceptance; changes while in_valid=0 or in_ready=0 have no effect.
REQ-022 SHALL allow multiple ack bits to be asserted simultaneously, each acting independently.
REQ-023 SHALL implement each channel as a 2-state machine: EMPTY (V=0) -> FULL on write; FULL -> EMPTY on ack without write; FULL -> FULL on write, which requires ack the same cycle per REQ-013.

Reset
REQ-024 SHALL, while rst_n=0, immediately drive Y0..Y6=0000, V=0000000, err=0 and drop_cnt=0000, independent of clk.
REQ-025 SHALL abandon any in-progress handshake on reset with no partial write; the first acceptance is possible at the first rising edge after rst_n deasserts.
REQ-026 SHALL drive in_ready=1 for all legal S during reset, because all channels are empty.

Verification
REQ-027 Basic route: D=1010, S=011, in_valid=1 for one cycle -> next cycle Y3=1010, V=0001000, all other Yk=0000.
REQ-028 Backpressure: V[5]=1, S=101, in_valid=1, ack=0 -> in_ready=0, Y5 unchanged; then assert ack[5]=1 -> in_ready=1, Y5 takes the new D, V[5] stays 1.
REQ-029 Illegal select: 17 accepted words with S=111 -> err pulses 17 times, drop_cnt=1111 (saturated), V unchanged.
REQ-030 Simultaneous: write S=000 D=0110 while ack=0000010 with V[1]=1 -> V[0]=1, V[1]=0, Y0=0110.
REQ-031 Async reset: V=1111111, pull rst_n low between clk edges -> V=0000000, all Yk=0000 and drop_cnt=0000 before the next edge.
REQ-032 Stale ack: ack=1111111 with V=0000000 -> no state change, err=0.
